// File: rtl/div32_iterative.sv
// div32_iterative: multi-cycle restoring divider for DIV/DIVU.
// Produces one quotient bit per clock. A start/busy/done handshake lets the
// hazard unit stall dependent HI/LO reads until the result is valid.
module div32_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    // One spare top bit so the shifted partial remainder never overflows
    logic [WIDTH:0]   rem;
    // Holds the dividend magnitude; quotient bits shift in from the bottom
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvsr;
    logic             sign_q;
    logic             sign_r;
    logic             dz;

    logic             dividend_neg;
    logic             divisor_neg;
    logic             divisor_zero;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH+1:0] rem_shift;
    logic [WIDTH+1:0] trial;
    logic             trial_neg;

    // Operand magnitudes at capture, and the shift-and-subtract trial step
    always_comb begin
        dividend_neg = is_signed & dividend[WIDTH-1];
        divisor_neg  = is_signed & divisor[WIDTH-1];
        divisor_zero = (divisor == '0);
        dividend_mag = dividend_neg ? -dividend : dividend;
        divisor_mag  = divisor_neg ? -divisor : divisor;
        rem_shift    = {rem, q[WIDTH-1]};
        trial        = rem_shift - {2'b00, dvsr};
        trial_neg    = trial[WIDTH+1];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a zero divisor skips straight to the result stage
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = divisor_zero ? FIX : RUN;
                end
            end
            RUN: begin
                if (count == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and result registers; done is a single-cycle pulse from FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            rem         <= '0;
            q           <= '0;
            dvsr        <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy   <= 1'b1;
                        count  <= CW'(WIDTH - 1);
                        rem    <= '0;
                        dvsr   <= divisor_mag;
                        sign_q <= dividend_neg ^ divisor_neg;
                        sign_r <= dividend_neg;
                        dz     <= divisor_zero;
                        q      <= divisor_zero ? dividend : dividend_mag;
                    end
                end
                RUN: begin
                    rem   <= trial_neg ? rem_shift[WIDTH:0] : trial[WIDTH:0];
                    q     <= {q[WIDTH-2:0], ~trial_neg};
                    count <= count - CW'(1);
                end
                FIX: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (dz) begin
                        quotient    <= '1;
                        remainder   <= q;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= sign_q ? -q : q;
                        remainder   <= sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
